// File: rtl/split_track_pkg.sv
// Shared helpers for the bus splitter: width math and counter step encoding.
// The error pseudo-slave id is always N_SLAVES, one past the last real slave.
package split_track_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

endpackage

// File: rtl/split_track_ctr.sv
// Read-tracking state for split_track: outstanding-read count, owner lock,
// and the one-cycle response pulse of the error pseudo-slave.
module split_track_ctr
  import split_track_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int MAX_OUT  = 4,
  parameter int ID_W     = clog2(N_SLAVES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            acc_rd,
  input  logic [ID_W-1:0] tgt,
  input  logic            rsp,
  output logic            cnt_zero,
  output logic            cnt_full,
  output logic [ID_W-1:0] lock,
  output logic            err_rv
);

  localparam int CNT_W = clog2(MAX_OUT + 1);
  localparam logic [ID_W-1:0] ERR_ID = ID_W'(N_SLAVES);

  logic [CNT_W-1:0] cnt;
  cnt_op_e          op;

  // Accept and response in the same cycle cancel out.
  always_comb begin
    op = CNT_HOLD;
    if (acc_rd && !rsp) begin
      op = CNT_INC;
    end else if (rsp && !acc_rd) begin
      op = CNT_DEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      lock   <= '0;
      err_rv <= 1'b0;
    end else begin
      case (op)
        CNT_INC: cnt <= cnt + CNT_W'(1);
        CNT_DEC: cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (acc_rd) begin
        lock <= tgt;
      end
      err_rv <= acc_rd && (tgt == ERR_ID);
    end
  end

  assign cnt_zero = (cnt == '0);
  assign cnt_full = (cnt == CNT_W'(MAX_OUT));

endmodule

// File: rtl/split_track.sv
// Address-decoded 1-to-N bus splitter; read responses are only accepted from
// the slave that owns the outstanding reads, unmapped selects hit an error slave.
module split_track
  import split_track_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int P_SEL    = ADDR_W - 1,
  parameter int MAX_OUT  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_valid,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_ready,
  output logic                       m_rvalid,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_err,
  output logic [N_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  input  logic [N_SLAVES-1:0]        s_ready,
  input  logic [N_SLAVES-1:0]        s_rvalid,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata
);

  localparam int N_SLAVES_W = clog2(N_SLAVES);
  localparam int ID_W       = clog2(N_SLAVES + 1);
  localparam logic [ID_W-1:0] ERR_ID = ID_W'(N_SLAVES);

  logic [N_SLAVES_W-1:0] sel;
  logic [ID_W-1:0]       sel_id;
  logic [ID_W-1:0]       tgt;
  logic [ID_W-1:0]       lock;
  logic                  hit;
  logic                  rd;
  logic                  stall;
  logic                  sel_ready;
  logic                  lock_rvalid;
  logic [DATA_W-1:0]     lock_rdata;
  logic                  acc_rd;
  logic                  rsp;
  logic                  cnt_zero;
  logic                  cnt_full;
  logic                  err_rv;

  assign sel    = m_addr[P_SEL -: N_SLAVES_W];
  assign sel_id = ID_W'(sel);
  assign hit    = (sel_id < ERR_ID);
  assign tgt    = hit ? sel_id : ERR_ID;
  assign rd     = (m_wstrb == '0);

  // Switching owner waits for the pipe to drain; a same-cycle response does not help.
  assign stall = (!cnt_zero && (tgt != lock)) || (cnt_full && rd);

  always_comb begin
    sel_ready   = 1'b0;
    lock_rvalid = 1'b0;
    lock_rdata  = '0;
    s_valid     = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_id == ID_W'(k)) begin
        sel_ready  = s_ready[k];
        s_valid[k] = m_valid && !stall;
      end
      if (lock == ID_W'(k)) begin
        lock_rvalid = s_rvalid[k];
        lock_rdata  = s_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign m_ready = !stall && (hit ? sel_ready : 1'b1);
  assign acc_rd  = m_valid && m_ready && rd;
  assign rsp     = !cnt_zero && ((lock < ERR_ID) ? lock_rvalid : err_rv);

  assign m_rvalid = rsp;
  assign m_rdata  = lock_rdata;
  assign m_err    = rsp && (lock == ERR_ID);

  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;

  split_track_ctr #(
    .N_SLAVES (N_SLAVES),
    .MAX_OUT  (MAX_OUT),
    .ID_W     (ID_W)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_rd   (acc_rd),
    .tgt      (tgt),
    .rsp      (rsp),
    .cnt_zero (cnt_zero),
    .cnt_full (cnt_full),
    .lock     (lock),
    .err_rv   (err_rv)
  );

endmodule

// File: tb/tb_split_track.sv
// Bench for split_track with three slaves: decode table at idle, then
// multi-cycle sequences checked by a read-response scoreboard.
module tb_split_track;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic            clk;
  logic            rst_n;
  logic            m_valid;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_ready;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic [N-1:0]    s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [N-1:0]    s_ready;
  logic [N-1:0]    s_rvalid;
  logic [N*DW-1:0] s_rdata;

  int tests = 0;
  int fails = 0;
  logic [DW:0] sb[$];
  bit probe;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [N-1:0]  rdy;
    logic [N-1:0]  exp_sv;
    logic          exp_mr;
  } vec_t;
  vec_t vt[8];

  split_track #(
    .N_SLAVES (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .P_SEL    (31),
    .MAX_OUT  (MO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return {a[15:0], 16'hCAFE};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response check first, then record a newly accepted read.
  task automatic mon();
    logic [DW:0] e;
    if (m_rvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'(m_rvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_rdata", m_rdata, e[DW-1:0]);
        chk("sb_err", 32'(m_err), 32'(e[DW]));
      end
    end
    if (!probe && m_valid && m_ready && (m_wstrb == '0)) begin
      if (m_addr[31:30] == 2'd3) sb.push_back({1'b1, 32'h0});
      else sb.push_back({1'b0, rd_model(m_addr)});
    end
  endtask

  task automatic req(input logic v, input logic [AW-1:0] a, input logic [SW-1:0] st);
    m_valid = v;
    m_addr  = a;
    m_wstrb = st;
    m_wdata = ~a;
  endtask

  task automatic rsp(input int k, input logic [DW-1:0] d);
    s_rvalid[k]            = 1'b1;
    s_rdata[k*DW +: DW]    = d;
  endtask

  task automatic smp();
    #3;
    mon();
  endtask

  task automatic nxt();
    @(negedge clk);
    s_rvalid = '0;
    probe    = 1'b0;
  endtask

  initial begin
    vt[0] = '{32'h4000_0010, 4'h0, 3'b010, 3'b010, 1'b1};
    vt[1] = '{32'h4000_0010, 4'h0, 3'b101, 3'b010, 1'b0};
    vt[2] = '{32'h0000_0000, 4'h0, 3'b001, 3'b001, 1'b1};
    vt[3] = '{32'h8000_0004, 4'hF, 3'b100, 3'b100, 1'b1};
    vt[4] = '{32'h8000_0004, 4'hF, 3'b011, 3'b100, 1'b0};
    vt[5] = '{32'hC000_0000, 4'h0, 3'b000, 3'b000, 1'b1};
    vt[6] = '{32'hFFFF_FFFC, 4'h1, 3'b111, 3'b000, 1'b1};
    vt[7] = '{32'h3FFF_FFFF, 4'h0, 3'b110, 3'b001, 1'b0};

    rst_n    = 1'b0;
    probe    = 1'b0;
    s_ready  = '0;
    s_rvalid = '1;
    s_rdata  = '1;
    req(1'b0, '0, '0);
    @(negedge clk);
    smp();
    chk("rst_rvalid", 32'(m_rvalid), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_svalid", 32'(s_valid), 32'd0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // Decode table at idle; m_valid dropped before the edge so nothing is accepted.
    foreach (vt[i]) begin
      probe   = 1'b1;
      s_ready = vt[i].rdy;
      req(1'b1, vt[i].addr, vt[i].strb);
      smp();
      chk($sformatf("tbl%0d_svalid", i), 32'(s_valid), 32'(vt[i].exp_sv));
      chk($sformatf("tbl%0d_mready", i), 32'(m_ready), 32'(vt[i].exp_mr));
      chk($sformatf("tbl%0d_saddr", i), s_addr, vt[i].addr);
      m_valid = 1'b0;
      nxt();
    end
    s_ready = '1;

    // Basic read to slave 1 with a two-cycle response.
    req(1'b1, 32'h4000_0010, 4'h0);
    smp();
    chk("a_svalid", 32'(s_valid), 32'b010);
    chk("a_mready", 32'(m_ready), 32'd1);
    nxt();
    req(1'b0, '0, '0);
    smp(); nxt();
    rsp(1, rd_model(32'h4000_0010));
    smp();
    chk("a_rvalid", 32'(m_rvalid), 32'd1);
    chk("a_rdata", m_rdata, 32'h0010_CAFE);
    nxt();
    req(1'b1, 32'h8000_0000, 4'h0);
    smp();
    chk("a_drained_mready", 32'(m_ready), 32'd1);
    nxt();
    req(1'b0, '0, '0);
    rsp(2, rd_model(32'h8000_0000));
    smp(); nxt();

    // Fill to MAX_OUT on slave 0, then one response frees a slot a cycle later.
    for (int i = 0; i < MO; i++) begin
      req(1'b1, 32'(i * 4), 4'h0);
      smp();
      chk($sformatf("b_acc%0d", i), 32'(m_ready), 32'd1);
      nxt();
    end
    req(1'b1, 32'h10, 4'h0);
    smp();
    chk("b_full_stall", 32'(m_ready), 32'd0);
    nxt();
    rsp(0, rd_model(32'h0));
    smp();
    chk("b_rsp_no_lift", 32'(m_ready), 32'd0);
    chk("b_rsp_rvalid", 32'(m_rvalid), 32'd1);
    nxt();
    smp();
    chk("b_fifth_acc", 32'(m_ready), 32'd1);
    nxt();
    req(1'b0, '0, '0);
    for (int i = 1; i <= MO; i++) begin
      rsp(0, rd_model(32'(i * 4)));
      smp(); nxt();
    end

    // Owner lock: slave 1 waits for slave 0 to drain; stray slave-1 response ignored.
    req(1'b1, 32'h0000_0100, 4'h0);
    smp(); nxt();
    req(1'b1, 32'h4000_0200, 4'h0);
    rsp(1, 32'hDEAD_BEEF);
    smp();
    chk("c_lock_mready", 32'(m_ready), 32'd0);
    chk("c_lock_svalid", 32'(s_valid), 32'd0);
    chk("c_stray_rvalid", 32'(m_rvalid), 32'd0);
    nxt();
    smp();
    chk("c_lock_hold", 32'(m_ready), 32'd0);
    nxt();
    rsp(0, rd_model(32'h0000_0100));
    smp();
    chk("c_rsp_no_lift", 32'(m_ready), 32'd0);
    nxt();
    smp();
    chk("c_switch_mready", 32'(m_ready), 32'd1);
    chk("c_switch_svalid", 32'(s_valid), 32'b010);
    nxt();
    req(1'b0, '0, '0);
    rsp(1, rd_model(32'h4000_0200));
    smp();
    chk("c_rvalid1", 32'(m_rvalid), 32'd1);
    nxt();

    // Unmapped read gets an error response; unmapped write is dropped.
    req(1'b1, 32'hC000_0000, 4'h0);
    smp();
    chk("d_mready", 32'(m_ready), 32'd1);
    chk("d_svalid", 32'(s_valid), 32'd0);
    nxt();
    req(1'b0, '0, '0);
    smp();
    chk("d_rvalid", 32'(m_rvalid), 32'd1);
    chk("d_err", 32'(m_err), 32'd1);
    chk("d_rdata", m_rdata, 32'd0);
    nxt();
    req(1'b1, 32'hC000_0008, 4'hF);
    smp();
    chk("d_wr_mready", 32'(m_ready), 32'd1);
    chk("d_wr_svalid", 32'(s_valid), 32'd0);
    nxt();
    req(1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      smp();
      chk($sformatf("d_wr_norsp%0d", i), 32'(m_rvalid), 32'd0);
      nxt();
    end

    // Accept plus response in one cycle keeps the count at 2, proven by the fill point.
    req(1'b1, 32'h8000_0000, 4'h0);
    smp(); nxt();
    req(1'b1, 32'h8000_0004, 4'h0);
    smp(); nxt();
    req(1'b1, 32'h8000_0008, 4'h0);
    rsp(2, rd_model(32'h8000_0000));
    smp();
    chk("e_acc_rsp", 32'(m_ready), 32'd1);
    nxt();
    req(1'b1, 32'h8000_000C, 4'h0);
    smp();
    chk("e_acc3", 32'(m_ready), 32'd1);
    nxt();
    req(1'b1, 32'h8000_0010, 4'h0);
    smp();
    chk("e_acc4", 32'(m_ready), 32'd1);
    nxt();
    req(1'b1, 32'h8000_0014, 4'h0);
    smp();
    chk("e_full", 32'(m_ready), 32'd0);
    nxt();
    req(1'b0, '0, '0);
    for (int i = 1; i <= 4; i++) begin
      rsp(2, rd_model(32'h8000_0000 + 32'(i * 4)));
      smp(); nxt();
    end

    // Reset with three reads outstanding; late responses must be dropped.
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 32'h4000_0000 + 32'(i * 4), 4'h0);
      smp(); nxt();
    end
    req(1'b0, '0, '0);
    rst_n = 1'b0;
    sb.delete();
    rsp(1, 32'h1234_5678);
    smp();
    chk("f_rst_rvalid", 32'(m_rvalid), 32'd0);
    chk("f_rst_svalid", 32'(s_valid), 32'd0);
    nxt();
    rst_n = 1'b1;
    rsp(1, 32'h1234_5678);
    smp();
    chk("f_late_rvalid", 32'(m_rvalid), 32'd0);
    nxt();
    req(1'b1, 32'h0000_0040, 4'h0);
    smp();
    chk("f_post_rst_acc", 32'(m_ready), 32'd1);
    nxt();
    req(1'b0, '0, '0);
    rsp(0, rd_model(32'h0000_0040));
    smp(); nxt();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
